// File: rtl/hermes_pkg.sv
// hermes_pkg: shared types for the Hermes link transmitter.
//   tx_fsm_t : one-hot packet framing state (IDLE, SIZE, PAYLOAD, LAST).
package hermes_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_SIZE    = 4'b0010,
    ST_PAYLOAD = 4'b0100,
    ST_LAST    = 4'b1000
  } tx_fsm_t;

endpackage

// File: rtl/hermes_tx_fifo.sv
// hermes_tx_fifo: circular staging FIFO with registered full/empty flags.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   push_i, wdata_i: write strobe (caller guarantees !full_o) and write data
//   pop_i          : read strobe (caller guarantees !empty_o)
//   rdata_o        : head entry (buffer[tail])
//   full_o, empty_o: occupancy flags
module hermes_tx_fifo #(
  parameter int BUFFER_SIZE = 4,
  parameter int FLIT_SIZE   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [FLIT_SIZE-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [FLIT_SIZE-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);

  logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
  logic [PTR_W-1:0]     head, tail;
  logic [PTR_W-1:0]     head_nxt, tail_nxt;

  // Power-of-two depth: pointers wrap by natural overflow.
  assign head_nxt = head + PTR_W'(1);
  assign tail_nxt = tail + PTR_W'(1);
  assign rdata_o  = mem[tail];

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[head] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head    <= '0;
      tail    <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      if (push_i) head <= head_nxt;
      if (pop_i)  tail <= tail_nxt;
      // Simultaneous push and pop keeps occupancy, so flags hold.
      if (push_i && !pop_i) begin
        empty_o <= 1'b0;
        if (head_nxt == tail) full_o <= 1'b1;
      end else if (pop_i && !push_i) begin
        full_o <= 1'b0;
        if (tail_nxt == head) empty_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hermes_tx.sv
// hermes_tx: credit-based Hermes link transmitter with packet framing monitor.
// Optional feature macro: HERMES_TX_STATS_EN (enables pkt/flit counters).
// Ports:
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   pe_valid_i, pe_data_i, pe_ready_o : producer valid/ready push interface
//   tx_o, data_o, credit_i            : Hermes link, transfer on tx_o && credit_i
//   busy_o                            : framing FSM outside IDLE
//   pkt_done_o, err_size_o            : registered one-cycle event pulses
//   pkt_cnt_o, flit_cnt_o             : statistics (0 when stats disabled)
//
// state      | meaning
// ST_IDLE    | waiting for a header flit to transfer
// ST_SIZE    | header sent, next transfer is the size flit
// ST_PAYLOAD | payload flits remain, more than one left
// ST_LAST    | exactly one payload flit remains
module hermes_tx
  import hermes_pkg::*;
#(
  parameter int BUFFER_SIZE = 4,
  parameter int FLIT_SIZE   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pe_valid_i,
  input  logic [FLIT_SIZE-1:0] pe_data_i,
  output logic                 pe_ready_o,
  output logic                 tx_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 credit_i,
  output logic                 busy_o,
  output logic                 pkt_done_o,
  output logic                 err_size_o,
  output logic [31:0]          pkt_cnt_o,
  output logic [31:0]          flit_cnt_o
);

  logic                 full, empty, push, xfer;
  logic                 done_set, err_set;
  logic [FLIT_SIZE-1:0] flit_cntr;
  tx_fsm_t              state, state_nxt;

  assign pe_ready_o = !full;
  assign tx_o       = !empty;
  assign push       = pe_valid_i && !full;
  assign xfer       = tx_o && credit_i;

  hermes_tx_fifo #(
    .BUFFER_SIZE (BUFFER_SIZE),
    .FLIT_SIZE   (FLIT_SIZE)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (pe_data_i),
    .pop_i   (xfer),
    .rdata_o (data_o),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      flit_cntr <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        if (state == ST_SIZE) flit_cntr <= data_o;
        else if (state == ST_PAYLOAD || state == ST_LAST) flit_cntr <= flit_cntr - FLIT_SIZE'(1);
      end
    end
  end

  // ST_LAST stands for "flit_cntr == 1", so the final payload transfer
  // needs no compare on the counter.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (xfer) state_nxt = ST_SIZE;
      ST_SIZE:
        if (xfer) begin
          if (data_o == '0)                  state_nxt = ST_IDLE;
          else if (data_o == FLIT_SIZE'(1))  state_nxt = ST_LAST;
          else                               state_nxt = ST_PAYLOAD;
        end
      ST_PAYLOAD: if (xfer && flit_cntr == FLIT_SIZE'(2)) state_nxt = ST_LAST;
      ST_LAST:    if (xfer) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state != ST_IDLE);
    err_set  = xfer && (state == ST_SIZE) && (data_o == '0);
    done_set = err_set || (xfer && (state == ST_LAST));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_done_o <= 1'b0;
      err_size_o <= 1'b0;
    end else begin
      pkt_done_o <= done_set;
      err_size_o <= err_set;
    end
  end

`ifdef HERMES_TX_STATS_EN
  logic [31:0] pkt_cnt_q, flit_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else begin
      if (done_set) pkt_cnt_q  <= pkt_cnt_q + 32'd1;
      if (xfer)     flit_cnt_q <= flit_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign flit_cnt_o = flit_cnt_q;
`else
  assign pkt_cnt_o  = '0;
  assign flit_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hermes_tx.sv
// tb_hermes_tx: directed self-checking bench for hermes_tx (BUFFER_SIZE=4).
module tb_hermes_tx;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pe_valid_i;
  logic [31:0] pe_data_i;
  logic        pe_ready_o;
  logic        tx_o;
  logic [31:0] data_o;
  logic        credit_i;
  logic        busy_o;
  logic        pkt_done_o;
  logic        err_size_o;
  logic [31:0] pkt_cnt_o;
  logic [31:0] flit_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;
  bit stats_en;

  hermes_tx #(.BUFFER_SIZE(4), .FLIT_SIZE(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .pe_valid_i (pe_valid_i),
    .pe_data_i  (pe_data_i),
    .pe_ready_o (pe_ready_o),
    .tx_o       (tx_o),
    .data_o     (data_o),
    .credit_i   (credit_i),
    .busy_o     (busy_o),
    .pkt_done_o (pkt_done_o),
    .err_size_o (err_size_o),
    .pkt_cnt_o  (pkt_cnt_o),
    .flit_cnt_o (flit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; pe_valid_i = 1'b0; pe_data_i = '0; credit_i = 1'b0;
    step(); step();
    n_chk++; if (pe_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", pe_ready_o); end
    n_chk++; if (tx_o !== 1'b0) begin n_fail++; $display("FAIL reset_tx: got %b want 0", tx_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_chk++; if (pkt_done_o !== 1'b0 || err_size_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b err=%b want 0/0", pkt_done_o, err_size_o); end
    n_chk++; if (pkt_cnt_o !== 32'd0 || flit_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got pkt=%0d flit=%0d want 0/0", pkt_cnt_o, flit_cnt_o); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic check_counters(input string name, input int exp_flits, input int exp_pkts);
    int ef, ep;
    ef = stats_en ? exp_flits : 0;
    ep = stats_en ? exp_pkts : 0;
    n_chk++; if (flit_cnt_o !== 32'(ef)) begin n_fail++; $display("FAIL %s_flit_cnt: got %0d want %0d", name, flit_cnt_o, ef); end
    n_chk++; if (pkt_cnt_o !== 32'(ep)) begin n_fail++; $display("FAIL %s_pkt_cnt: got %0d want %0d", name, pkt_cnt_o, ep); end
  endtask

  task automatic test_basic_packet();
    logic [31:0] pk [4] = '{32'h0000_0102, 32'd2, 32'hAAAA_0001, 32'hBBBB_0002};
    credit_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pe_valid_i = 1'b1; pe_data_i = pk[i];
      step();
    end
    pe_valid_i = 1'b0;
    n_chk++; if (pe_ready_o !== 1'b0) begin n_fail++; $display("FAIL basic_full_ready: got %b want 0", pe_ready_o); end
    credit_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (tx_o !== 1'b1 || data_o !== pk[i]) begin n_fail++; $display("FAIL basic_flit%0d: got tx=%b data=%h want 1/%h", i, tx_o, data_o, pk[i]); end
      n_chk++; if (busy_o !== (i != 0)) begin n_fail++; $display("FAIL basic_busy%0d: got %b want %b", i, busy_o, (i != 0)); end
      n_chk++; if (pkt_done_o !== 1'b0) begin n_fail++; $display("FAIL basic_early_done%0d: got %b want 0", i, pkt_done_o); end
      step();
    end
    credit_i = 1'b0;
    n_chk++; if (pkt_done_o !== 1'b1 || busy_o !== 1'b0 || tx_o !== 1'b0) begin n_fail++; $display("FAIL basic_end: got done=%b busy=%b tx=%b want 1/0/0", pkt_done_o, busy_o, tx_o); end
    check_counters("basic", 4, 1);
    step();
    n_chk++; if (pkt_done_o !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", pkt_done_o); end
  endtask

  task automatic test_credit_toggle();
    logic [31:0] pk [4] = '{32'h0000_0102, 32'd2, 32'hAAAA_0001, 32'hBBBB_0002};
    int idx;
    credit_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pe_valid_i = 1'b1; pe_data_i = pk[i];
      step();
    end
    pe_valid_i = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      credit_i = (cyc % 2 == 0);
      n_chk++; if (tx_o !== (idx < 4)) begin n_fail++; $display("FAIL toggle_tx%0d: got %b want %b", cyc, tx_o, (idx < 4)); end
      if (idx < 4) begin
        n_chk++; if (data_o !== pk[idx]) begin n_fail++; $display("FAIL toggle_data%0d: got %h want %h", cyc, data_o, pk[idx]); end
      end
      n_chk++; if (pkt_done_o !== (cyc == 7)) begin n_fail++; $display("FAIL toggle_done%0d: got %b want %b", cyc, pkt_done_o, (cyc == 7)); end
      step();
      if (credit_i) idx++;
    end
    credit_i = 1'b0;
    check_counters("toggle", 8, 2);
  endtask

  task automatic test_full();
    logic [31:0] f [5] = '{32'h0000_00A0, 32'd3, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
    credit_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pe_valid_i = 1'b1; pe_data_i = f[i];
      n_chk++; if (pe_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready_fill%0d: got %b want 1", i, pe_ready_o); end
      step();
    end
    n_chk++; if (pe_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready_after4: got %b want 0", pe_ready_o); end
    pe_data_i = f[4];
    step();
    n_chk++; if (pe_ready_o !== 1'b0 || data_o !== f[0]) begin n_fail++; $display("FAIL full_hold: got ready=%b data=%h want 0/%h", pe_ready_o, data_o, f[0]); end
    credit_i = 1'b1;
    step();
    n_chk++; if (pe_ready_o !== 1'b1 || data_o !== f[1]) begin n_fail++; $display("FAIL full_first_pop: got ready=%b data=%h want 1/%h", pe_ready_o, data_o, f[1]); end
    step();
    pe_valid_i = 1'b0;
    for (int i = 2; i < 5; i++) begin
      n_chk++; if (tx_o !== 1'b1 || data_o !== f[i]) begin n_fail++; $display("FAIL full_drain%0d: got tx=%b data=%h want 1/%h", i, tx_o, data_o, f[i]); end
      step();
    end
    n_chk++; if (tx_o !== 1'b0 || pkt_done_o !== 1'b1) begin n_fail++; $display("FAIL full_end: got tx=%b done=%b want 0/1", tx_o, pkt_done_o); end
    credit_i = 1'b0;
    check_counters("full", 13, 3);
  endtask

  task automatic test_size_zero();
    logic [31:0] d [5] = '{32'h0000_0011, 32'd0, 32'h0000_0022, 32'd1, 32'h0000_0033};
    logic        bexp [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    credit_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pe_valid_i = 1'b1; pe_data_i = d[i];
      step();
      n_chk++; if (tx_o !== 1'b1 || data_o !== d[i]) begin n_fail++; $display("FAIL size0_flit%0d: got tx=%b data=%h want 1/%h", i, tx_o, data_o, d[i]); end
      n_chk++; if (err_size_o !== (i == 2) || pkt_done_o !== (i == 2)) begin n_fail++; $display("FAIL size0_pulse%0d: got err=%b done=%b want %b/%b", i, err_size_o, pkt_done_o, (i == 2), (i == 2)); end
      n_chk++; if (busy_o !== bexp[i]) begin n_fail++; $display("FAIL size0_busy%0d: got %b want %b", i, busy_o, bexp[i]); end
    end
    pe_valid_i = 1'b0;
    step();
    n_chk++; if (pkt_done_o !== 1'b1 || err_size_o !== 1'b0 || busy_o !== 1'b0 || tx_o !== 1'b0) begin n_fail++; $display("FAIL size0_h2_done: got done=%b err=%b busy=%b tx=%b want 1/0/0/0", pkt_done_o, err_size_o, busy_o, tx_o); end
    credit_i = 1'b0;
    check_counters("size0", 18, 5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [6] = '{32'h0000_0061, 32'd1, 32'h0000_0062, 32'h0000_0071, 32'd1, 32'h0000_0072};
    logic        bexp [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    credit_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pe_valid_i = 1'b1; pe_data_i = d[i];
      n_chk++; if (pe_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", i, pe_ready_o); end
      step();
      n_chk++; if (tx_o !== 1'b1 || data_o !== d[i]) begin n_fail++; $display("FAIL b2b_flit%0d: got tx=%b data=%h want 1/%h", i, tx_o, data_o, d[i]); end
      n_chk++; if (pkt_done_o !== (i == 3)) begin n_fail++; $display("FAIL b2b_done%0d: got %b want %b", i, pkt_done_o, (i == 3)); end
      n_chk++; if (busy_o !== bexp[i]) begin n_fail++; $display("FAIL b2b_busy%0d: got %b want %b", i, busy_o, bexp[i]); end
    end
    pe_valid_i = 1'b0;
    step();
    n_chk++; if (pkt_done_o !== 1'b1 || busy_o !== 1'b0 || tx_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got done=%b busy=%b tx=%b want 1/0/0", pkt_done_o, busy_o, tx_o); end
    credit_i = 1'b0;
    check_counters("b2b", 24, 7);
  endtask

  task automatic test_reset_mid_packet();
    credit_i = 1'b1;
    pe_valid_i = 1'b1; pe_data_i = 32'h0000_0044; step();
    pe_data_i = 32'd8; step();
    pe_data_i = 32'h0000_00AB; step();
    n_chk++; if (busy_o !== 1'b1 || tx_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got busy=%b tx=%b want 1/1", busy_o, tx_o); end
    rst_i = 1'b1; pe_valid_i = 1'b0;
    step();
    n_chk++; if (tx_o !== 1'b0 || busy_o !== 1'b0 || pe_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: got tx=%b busy=%b ready=%b want 0/0/1", tx_o, busy_o, pe_ready_o); end
    n_chk++; if (pkt_done_o !== 1'b0 || err_size_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulses: got done=%b err=%b want 0/0", pkt_done_o, err_size_o); end
    check_counters("rstmid", 0, 0);
    rst_i = 1'b0;
    pe_valid_i = 1'b1; pe_data_i = 32'h0000_0055; step();
    n_chk++; if (busy_o !== 1'b0 || tx_o !== 1'b1 || data_o !== 32'h0000_0055) begin n_fail++; $display("FAIL rstmid_hdr: got busy=%b tx=%b data=%h want 0/1/00000055", busy_o, tx_o, data_o); end
    pe_data_i = 32'd0; step();
    n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_size_state: got busy=%b want 1", busy_o); end
    pe_valid_i = 1'b0; step();
    n_chk++; if (err_size_o !== 1'b1 || pkt_done_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_reframe: got err=%b done=%b busy=%b want 1/1/0", err_size_o, pkt_done_o, busy_o); end
    credit_i = 1'b0;
    check_counters("rstmid_after", 2, 1);
  endtask

  initial begin
`ifdef HERMES_TX_STATS_EN
    stats_en = 1'b1;
`else
    stats_en = 1'b0;
`endif
    test_reset();
    test_basic_packet();
    test_credit_toggle();
    test_full();
    test_size_zero();
    test_back_to_back();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
